// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle A - B - Bin on WIDTH-bit operands, SLICE bits per clock,
// with a registered borrow chain and results held until the next operation completes.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_params
         $error("serial_subtractor: WIDTH must be >= 2 and divisible by SLICE");
      end
   endgenerate

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_r;
   // Minuend drains out of the bottom while the difference fills in from the top,
   // so one register doubles as operand shifter and result accumulator.
   logic [WIDTH-1:0] work_r;
   logic [WIDTH-1:0] sub_r;
   logic             borrow_r;
   logic [CW-1:0]    cnt_r;
   logic             a_msb_r;
   logic             b_msb_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] diff_r;
   logic             bout_r;
   logic             ovf_r;

   logic [SLICE:0]   slice_s;
   logic [WIDTH-1:0] work_next_s;
   logic [WIDTH-1:0] sub_next_s;
   logic             last_s;
   logic             accept_s;

   // Slice subtractor and control decode; a completing edge can also accept a new start.
   always_comb begin
      slice_s  = {1'b0, work_r[SLICE-1:0]} - {1'b0, sub_r[SLICE-1:0]} - {{SLICE{1'b0}}, borrow_r};
      last_s   = (state_r == RUN) && (cnt_r == CW'(N - 1));
      accept_s = start && ((state_r == IDLE) || last_s);
   end

   generate
      if (SLICE == WIDTH) begin : g_one_slice
         assign work_next_s = slice_s[SLICE-1:0];
         assign sub_next_s  = {WIDTH{1'b0}};
      end else begin : g_multi_slice
         assign work_next_s = {slice_s[SLICE-1:0], work_r[WIDTH-1:SLICE]};
         assign sub_next_s  = {{SLICE{1'b0}}, sub_r[WIDTH-1:SLICE]};
      end
   endgenerate

   // Control FSM, datapath shifting and registered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         work_r   <= {WIDTH{1'b0}};
         sub_r    <= {WIDTH{1'b0}};
         borrow_r <= 1'b0;
         cnt_r    <= {CW{1'b0}};
         a_msb_r  <= 1'b0;
         b_msb_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         diff_r   <= {WIDTH{1'b0}};
         bout_r   <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (last_s) begin
            diff_r <= work_next_s;
            bout_r <= slice_s[SLICE];
            ovf_r  <= (a_msb_r ^ b_msb_r) & (work_next_s[WIDTH-1] ^ a_msb_r);
            done_r <= 1'b1;
         end
         if (accept_s) begin
            state_r  <= RUN;
            work_r   <= a;
            sub_r    <= b;
            borrow_r <= bin;
            cnt_r    <= {CW{1'b0}};
            a_msb_r  <= a[WIDTH-1];
            b_msb_r  <= b[WIDTH-1];
            busy_r   <= 1'b1;
         end else begin
            case (state_r)
               IDLE: begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
               RUN: begin
                  work_r   <= work_next_s;
                  sub_r    <= sub_next_s;
                  borrow_r <= slice_s[SLICE];
                  cnt_r    <= cnt_r + CW'(1);
                  if (last_s) begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r <= RUN;
                     busy_r  <= 1'b1;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign diff = diff_r;
   assign bout = bout_r;
   assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor: 8/1, 16/4 and 8/8 configurations.
module tb_serial_subtractor;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       p_start = 1'b0, p_bin = 1'b0;
   logic [7:0] p_a = 8'h00, p_b = 8'h00;
   logic       p_busy, p_done, p_bout, p_ovf;
   logic [7:0] p_diff;

   logic        q_start = 1'b0, q_bin = 1'b0;
   logic [15:0] q_a = 16'h0000, q_b = 16'h0000;
   logic        q_busy, q_done, q_bout, q_ovf;
   logic [15:0] q_diff;

   logic       r_start = 1'b0, r_bin = 1'b0;
   logic [7:0] r_a = 8'h00, r_b = 8'h00;
   logic       r_busy, r_done, r_bout, r_ovf;
   logic [7:0] r_diff;

   int n_checks = 0;
   int n_fail   = 0;

   serial_subtractor #(.WIDTH(8), .SLICE(1)) u_p (
      .clk(clk), .rst_n(rst_n), .start(p_start), .a(p_a), .b(p_b), .bin(p_bin),
      .busy(p_busy), .done(p_done), .diff(p_diff), .bout(p_bout), .ovf(p_ovf));

   serial_subtractor #(.WIDTH(16), .SLICE(4)) u_q (
      .clk(clk), .rst_n(rst_n), .start(q_start), .a(q_a), .b(q_b), .bin(q_bin),
      .busy(q_busy), .done(q_done), .diff(q_diff), .bout(q_bout), .ovf(q_ovf));

   serial_subtractor #(.WIDTH(8), .SLICE(8)) u_r (
      .clk(clk), .rst_n(rst_n), .start(r_start), .a(r_a), .b(r_b), .bin(r_bin),
      .busy(r_busy), .done(r_done), .diff(r_diff), .bout(r_bout), .ovf(r_ovf));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({p_busy, p_done, p_bout, p_ovf, p_diff} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_8x1 got %h want 000", {p_busy, p_done, p_bout, p_ovf, p_diff});
      end
      n_checks++;
      if ({q_busy, q_done, q_bout, q_ovf, q_diff} !== 20'h00000) begin
         n_fail++;
         $display("FAIL reset_16x4 got %h want 00000", {q_busy, q_done, q_bout, q_ovf, q_diff});
      end
      n_checks++;
      if ({r_busy, r_done, r_bout, r_ovf, r_diff} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_8x8 got %h want 000", {r_busy, r_done, r_bout, r_ovf, r_diff});
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_basic_vectors();
      logic [7:0] ta [5] = '{8'h05, 8'h00, 8'h03, 8'h80, 8'h7F};
      logic [7:0] tb [5] = '{8'h03, 8'h01, 8'h03, 8'h01, 8'hFF};
      logic       tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [7:0] td [5] = '{8'h02, 8'hFF, 8'hFF, 8'h7F, 8'h80};
      logic       tbo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic       tov [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [9:0] held;
      held = 10'h000;
      for (int i = 0; i < 5; i++) begin
         p_a = ta[i]; p_b = tb[i]; p_bin = tc[i]; p_start = 1'b1;
         tick();
         p_start = 1'b0;
         p_a = 8'hC3; p_b = 8'h3C; p_bin = 1'b1;
         for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({p_busy, p_done, p_bout, p_ovf, p_diff} !== {1'b1, 1'b0, held}) begin
               n_fail++;
               $display("FAIL run_hold v%0d c%0d got %h want %h", i, k,
                        {p_busy, p_done, p_bout, p_ovf, p_diff}, {1'b1, 1'b0, held});
            end
            if (k < 7) tick();
         end
         tick();
         n_checks++;
         if ({p_busy, p_done, p_bout, p_ovf, p_diff} !== {1'b0, 1'b1, tbo[i], tov[i], td[i]}) begin
            n_fail++;
            $display("FAIL result v%0d got %h want %h", i,
                     {p_busy, p_done, p_bout, p_ovf, p_diff}, {1'b0, 1'b1, tbo[i], tov[i], td[i]});
         end
         held = {tbo[i], tov[i], td[i]};
      end
      tick();
      n_checks++;
      if ({p_busy, p_done} !== 2'b00) begin
         n_fail++;
         $display("FAIL done_fall got %b want 00", {p_busy, p_done});
      end
   endtask

   task automatic test_ignore_start();
      p_a = 8'h05; p_b = 8'h03; p_bin = 1'b0; p_start = 1'b1;
      tick();
      p_start = 1'b0;
      tick();
      tick();
      p_a = 8'hFF; p_b = 8'h00; p_start = 1'b1;
      tick();
      p_start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      n_checks++;
      if ({p_busy, p_done, p_bout, p_ovf, p_diff} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h02}) begin
         n_fail++;
         $display("FAIL ignore_start got %h want 402", {p_busy, p_done, p_bout, p_ovf, p_diff});
      end
      tick();
      n_checks++;
      if ({p_busy, p_done} !== 2'b00) begin
         n_fail++;
         $display("FAIL ignore_not_queued got %b want 00", {p_busy, p_done});
      end
   endtask

   task automatic test_back_to_back();
      q_a = 16'h1234; q_b = 16'h0235; q_bin = 1'b0; q_start = 1'b1;
      tick();
      q_start = 1'b0;
      tick();
      tick();
      tick();
      n_checks++;
      if ({q_busy, q_done} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_busy got %b want 10", {q_busy, q_done});
      end
      q_a = 16'h0000; q_b = 16'hFFFF; q_bin = 1'b1; q_start = 1'b1;
      tick();
      q_start = 1'b0;
      q_a = 16'hDEAD; q_b = 16'hBEEF; q_bin = 1'b0;
      n_checks++;
      if ({q_done, q_bout, q_ovf, q_diff} !== {1'b1, 1'b0, 1'b0, 16'h0FFF}) begin
         n_fail++;
         $display("FAIL b2b_first got %h want 40fff", {q_done, q_bout, q_ovf, q_diff});
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if ({q_busy, q_done, q_diff} !== {1'b1, 1'b0, 16'h0FFF}) begin
            n_fail++;
            $display("FAIL b2b_run c%0d got %h want 20fff", k, {q_busy, q_done, q_diff});
         end
      end
      tick();
      n_checks++;
      if ({q_busy, q_done, q_bout, q_ovf, q_diff} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL b2b_second got %h want 60000", {q_busy, q_done, q_bout, q_ovf, q_diff});
      end
      tick();
      n_checks++;
      if (q_done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done_fall got %b want 0", q_done);
      end
   endtask

   task automatic test_single_cycle();
      logic [7:0] ta [4] = '{8'h10, 8'h00, 8'h80, 8'hAA};
      logic [7:0] tb [4] = '{8'h01, 8'h00, 8'h7F, 8'h55};
      logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [9:0] te [4] = '{{1'b0, 1'b0, 8'h0F}, {1'b1, 1'b0, 8'hFF},
                             {1'b0, 1'b1, 8'h01}, {1'b0, 1'b1, 8'h55}};
      r_a = ta[0]; r_b = tb[0]; r_bin = tc[0]; r_start = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) begin
         if (i < 4) begin
            r_a = ta[i]; r_b = tb[i]; r_bin = tc[i];
         end else begin
            r_start = 1'b0;
         end
         tick();
         n_checks++;
         if ({r_done, r_bout, r_ovf, r_diff} !== {1'b1, te[i-1]}) begin
            n_fail++;
            $display("FAIL single_cycle v%0d got %h want %h", i - 1,
                     {r_done, r_bout, r_ovf, r_diff}, {1'b1, te[i-1]});
         end
      end
      tick();
      n_checks++;
      if ({r_busy, r_done} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_cycle_idle got %b want 00", {r_busy, r_done});
      end
   endtask

   task automatic test_reset_mid_run();
      p_a = 8'h05; p_b = 8'h03; p_bin = 1'b0; p_start = 1'b1;
      tick();
      p_start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({p_busy, p_done, p_bout, p_ovf, p_diff} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_mid_run got %h want 000", {p_busy, p_done, p_bout, p_ovf, p_diff});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         n_checks++;
         if ({p_busy, p_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL no_done_after_reset c%0d got %b want 00", k, {p_busy, p_done});
         end
      end
      p_a = 8'h80; p_b = 8'h01; p_bin = 1'b0; p_start = 1'b1;
      tick();
      p_start = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      n_checks++;
      if ({p_busy, p_done, p_bout, p_ovf, p_diff} !== {1'b0, 1'b1, 1'b0, 1'b1, 8'h7F}) begin
         n_fail++;
         $display("FAIL after_reset got %h want 57f", {p_busy, p_done, p_bout, p_ovf, p_diff});
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_basic_vectors();
      test_ignore_start();
      test_back_to_back();
      test_single_cycle();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
